// File: rtl/mdu_iterative.sv
// Iterative RV M-extension multiply/divide unit: shift-add multiply, restoring radix-2 divide.
// Optional build macro MDU_DIV_SHORTCUT_EN lets trivial divides skip the iteration phase.
module mdu_iterative #(
  parameter int XLEN    = 32,
  parameter int MUL_BPC = 2
) (
  input  logic            s_clk_i,
  input  logic            s_resetn_i,
  input  logic            s_stall_i,
  input  logic            s_flush_i,
  input  logic            s_compute_i,
  input  logic [2:0]      s_function_i,
  input  logic [XLEN-1:0] s_operand1_i,
  input  logic [XLEN-1:0] s_operand2_i,
  output logic            s_busy_o,
  output logic            s_finished_o,
  output logic [XLEN-1:0] s_result_o
);

  localparam int CW = $clog2(XLEN + 1);
  localparam int PW = XLEN + MUL_BPC;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q;
  logic [2:0]        fn_q;
  logic [2*XLEN-1:0] acc_q, acc_n;
  logic [XLEN-1:0]   mcand_q;
  logic              neg_q, rneg_q, div0_q;
  logic [XLEN-1:0]   result_q, fin_res, sc_res;

  function automatic logic [XLEN-1:0] neg_x(input logic [XLEN-1:0] v, input logic en);
    return en ? (~v) + XLEN'(1) : v;
  endfunction

  function automatic logic [2*XLEN-1:0] neg_2x(input logic [2*XLEN-1:0] v, input logic en);
    return en ? (~v) + (2*XLEN)'(1) : v;
  endfunction

  logic            is_div, s1, s2, a_neg, b_neg, sc_hit, start, last, done_wr;
  logic [XLEN-1:0] a_mag, b_mag;

  always_comb begin
    is_div = s_function_i[2];
    s1     = (s_function_i == 3'b001) || (s_function_i == 3'b010) ||
             (s_function_i == 3'b100) || (s_function_i == 3'b110);
    s2     = (s_function_i == 3'b001) || (s_function_i == 3'b100) || (s_function_i == 3'b110);
    a_neg  = s1 & s_operand1_i[XLEN-1];
    b_neg  = s2 & s_operand2_i[XLEN-1];
    a_mag  = neg_x(s_operand1_i, a_neg);
    b_mag  = neg_x(s_operand2_i, b_neg);
  end

`ifdef MDU_DIV_SHORTCUT_EN
  logic ovf, dz, small;
  logic [XLEN-1:0] sc_q, sc_r;
  always_comb begin
    dz     = (s_operand2_i == '0);
    ovf    = ~s_function_i[0] && (s_operand1_i == {1'b1, {(XLEN-1){1'b0}}}) &&
             (s_operand2_i == '1);
    small  = (a_mag < b_mag);
    sc_hit = is_div & (dz | ovf | small);
    sc_q   = dz ? '1 : (ovf ? s_operand1_i : '0);
    sc_r   = ovf ? '0 : s_operand1_i;
    sc_res = s_function_i[1] ? sc_r : sc_q;
  end
`else
  assign sc_hit = 1'b0;
  assign sc_res = '0;
`endif

  logic [PW-1:0]   mprod, msum;
  logic [XLEN:0]   rsh, rdiff;
  logic            ge;
  logic [2*XLEN-1:0] pfix;

  // One iteration step of either datapath, plus the sign-corrected final result.
  always_comb begin
    mprod = PW'(mcand_q) * PW'(acc_q[MUL_BPC-1:0]);
    msum  = PW'(acc_q[2*XLEN-1:XLEN]) + mprod;
    rsh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    rdiff = rsh - {1'b0, mcand_q};
    ge    = ~rdiff[XLEN];
    if (fn_q[2])
      acc_n = {(ge ? rdiff[XLEN-1:0] : rsh[XLEN-1:0]), acc_q[XLEN-2:0], ge};
    else
      acc_n = {msum, acc_q[XLEN-1:MUL_BPC]};
    pfix = neg_2x(acc_n, neg_q);
    if (fn_q[2]) begin
      // Signed overflow falls out naturally: |q| = 2^(XLEN-1) with no negation.
      if (fn_q[1]) fin_res = neg_x(acc_n[2*XLEN-1:XLEN], rneg_q);
      else         fin_res = div0_q ? '1 : neg_x(acc_n[XLEN-1:0], neg_q);
    end else begin
      fin_res = (fn_q == 3'b000) ? pfix[XLEN-1:0] : pfix[2*XLEN-1:XLEN];
    end
  end

  assign start   = (state_q == IDLE) & s_compute_i & ~s_flush_i;
  assign last    = (cnt_q == CW'(1));
  assign done_wr = ((state_q == RUN) & s_compute_i & ~s_flush_i & last) | (start & sc_hit);

  always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
    if (!s_resetn_i) state_q <= IDLE;
    else             state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = sc_hit ? DONE : RUN;
      RUN:     if (s_flush_i || !s_compute_i) state_d = IDLE;
               else if (last)                 state_d = DONE;
      DONE:    if (s_flush_i || !s_compute_i || !s_stall_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s_busy_o     = (state_q == RUN);
    s_finished_o = (state_q == DONE);
    s_result_o   = result_q;
  end

  always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
    if (!s_resetn_i) begin
      cnt_q    <= '0;
      fn_q     <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      div0_q   <= 1'b0;
      result_q <= '0;
    end else begin
      if (start) begin
        fn_q    <= s_function_i;
        neg_q   <= a_neg ^ b_neg;
        rneg_q  <= a_neg;
        div0_q  <= (s_operand2_i == '0);
        mcand_q <= is_div ? b_mag : a_mag;
        acc_q   <= {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
        cnt_q   <= is_div ? CW'(XLEN) : CW'(XLEN / MUL_BPC);
      end else if (state_q == RUN) begin
        acc_q <= acc_n;
        cnt_q <= cnt_q - CW'(1);
      end
      if (done_wr) result_q <= start ? sc_res : fin_res;
    end
  end

endmodule

// File: tb/tb_mdu_iterative.sv
// Self-checking bench for mdu_iterative: directed plan cases, randomized ops vs. arithmetic model,
// flush/abort, stall hold and asynchronous reset.
module tb_mdu_iterative;
  localparam int XLEN    = 32;
  localparam int MUL_BPC = 2;

  logic        clk = 1'b0;
  logic        rst_n, stall, flush, compute;
  logic [2:0]  fn;
  logic [31:0] op1, op2;
  logic        busy, fin;
  logic [31:0] res;

  int checks   = 0;
  int failures = 0;

  mdu_iterative #(.XLEN(XLEN), .MUL_BPC(MUL_BPC)) dut (
    .s_clk_i(clk), .s_resetn_i(rst_n), .s_stall_i(stall), .s_flush_i(flush),
    .s_compute_i(compute), .s_function_i(fn), .s_operand1_i(op1), .s_operand2_i(op2),
    .s_busy_o(busy), .s_finished_o(fin), .s_result_o(res)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub, p;
    logic [63:0] pv;
    logic ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = longint'({32'b0, a});
    ub  = longint'({32'b0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      3'd0: begin p = ua * ub; pv = p; return pv[31:0];  end
      3'd1: begin p = sa * sb; pv = p; return pv[63:32]; end
      3'd2: begin p = sa * ub; pv = p; return pv[63:32]; end
      3'd3: begin p = ua * ub; pv = p; return pv[63:32]; end
      3'd4: begin if (b == 0) return '1; if (ovf) return a; p = sa / sb; pv = p; return pv[31:0]; end
      3'd5: begin if (b == 0) return '1; p = ua / ub; pv = p; return pv[31:0]; end
      3'd6: begin if (b == 0) return a; if (ovf) return '0; p = sa % sb; pv = p; return pv[31:0]; end
      default: begin if (b == 0) return a; p = ua % ub; pv = p; return pv[31:0]; end
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
`ifdef MDU_DIV_SHORTCUT_EN
    longint ma, mb;
    bit sgn;
`endif
    if (!f[2]) return XLEN / MUL_BPC + 1;
`ifdef MDU_DIV_SHORTCUT_EN
    sgn = !f[0];
    ma  = sgn ? longint'($signed(a)) : longint'({32'b0, a});
    mb  = sgn ? longint'($signed(b)) : longint'({32'b0, b});
    if (ma < 0) ma = -ma;
    if (mb < 0) mb = -mb;
    if (b == 0 || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) || ma < mb) return 1;
`endif
    return XLEN + 1;
  endfunction

  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input int stall_cycles);
    logic [31:0] e;
    int el, cyc;
    bit seen;
    e    = ref_res(f, a, b);
    el   = ref_lat(f, a, b);
    cyc  = 0;
    seen = 0;
    @(posedge clk); #1;
    fn = f; op1 = a; op2 = b; compute = 1'b1;
    while (!seen && cyc < 80) begin
      @(posedge clk); cyc++;
      @(negedge clk);
      if (cyc == 1) chk({tag, " busy"}, 64'(busy), 64'(el > 1));
      if (fin) seen = 1;
    end
    chk({tag, " latency"}, 64'(cyc), 64'(el));
    chk({tag, " result"}, 64'(res), 64'(e));
    if (seen) begin
      stall = (stall_cycles > 0);
      for (int i = 0; i < stall_cycles; i++) begin
        @(posedge clk); @(negedge clk);
        chk({tag, " stall fin"}, 64'(fin), 64'd1);
        chk({tag, " stall res"}, 64'(res), 64'(e));
      end
      stall = 1'b0;
      @(posedge clk); #1;
      compute = 1'b0;
      chk({tag, " release"}, 64'(fin), 64'd0);
    end
  endtask

  initial begin
    logic [2:0]  rf;
    logic [31:0] ra, rb;
    logic [31:0] corner [4];
    bit rose;
    corner[0] = 32'h0; corner[1] = 32'h1; corner[2] = 32'hFFFF_FFFF; corner[3] = 32'h8000_0000;
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; compute = 1'b0;
    fn = '0; op1 = '0; op2 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset fin", 64'(fin), 64'd0);
    chk("reset res", 64'(res), 64'd0);
    @(negedge clk) rst_n = 1'b1;

    run_op("MUL", 3'd0, 32'h0001_2345, 32'h0000_1000, 0);
    run_op("MULH", 3'd1, 32'h8000_0000, 32'h8000_0000, 0);
    run_op("MULHSU", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op("MULHU", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op("DIV -7/2", 3'd4, 32'hFFFF_FFF9, 32'd2, 0);
    run_op("REM -7/2", 3'd6, 32'hFFFF_FFF9, 32'd2, 0);
    run_op("DIVU 100/7", 3'd5, 32'd100, 32'd7, 0);
    run_op("DIV 5/0", 3'd4, 32'd5, 32'd0, 0);
    run_op("REM 5/0", 3'd6, 32'd5, 32'd0, 0);
    run_op("DIV ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("REM ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("REMU small", 3'd7, 32'd3, 32'd9, 0);
    run_op("DIV -3/7", 3'd4, 32'hFFFF_FFFD, 32'd7, 0);

    // Flush during cycle 5 of a divide
    @(posedge clk); #1;
    fn = 3'd4; op1 = 32'd1000; op2 = 32'd7; compute = 1'b1;
    repeat (5) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; compute = 1'b0;
    chk("flush busy", 64'(busy), 64'd0);
    rose = fin;
    @(negedge clk); if (fin) rose = 1;
    @(negedge clk); if (fin) rose = 1;
    chk("flush no fin", 64'(rose), 64'd0);
    run_op("MUL after flush", 3'd0, 32'd12345, 32'd678, 0);

    // Dropping compute while running also aborts
    @(posedge clk); #1;
    fn = 3'd0; op1 = 32'd77; op2 = 32'd88; compute = 1'b1;
    repeat (3) @(posedge clk);
    #1 compute = 1'b0;
    @(posedge clk); #1;
    chk("abort busy", 64'(busy), 64'd0);

    run_op("stall MULHU", 3'd3, 32'hDEAD_BEEF, 32'h1234_5678, 4);

    for (int i = 0; i < 24; i++) begin
      rf = 3'($urandom_range(0, 7));
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = $urandom;
        1: rb = 32'($urandom_range(0, 15));
        2: begin ra = corner[$urandom_range(0, 3)]; rb = corner[$urandom_range(0, 3)]; end
        default: rb = ra >> $urandom_range(0, 31);
      endcase
      if ((i % 2) == 1 && $urandom_range(0, 1) == 1) ra = -ra;
      run_op($sformatf("rand%0d f%0d", i, rf), rf, ra, rb, int'($urandom_range(0, 2)));
    end

    // Asynchronous reset in the middle of a run
    @(posedge clk); #1;
    fn = 3'd1; op1 = 32'h1234_5678; op2 = 32'h8765_4321; compute = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("async rst busy", 64'(busy), 64'd0);
    chk("async rst fin", 64'(fin), 64'd0);
    chk("async rst res", 64'(res), 64'd0);
    compute = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    run_op("MULH after reset", 3'd1, 32'h1234_5678, 32'h8765_4321, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
